// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared constants for the four-way junction phase scheduler: lamp codes,
// phase encoding, direction indices and the default countdown width.
package traffic_pkg;

    localparam int CNT_W_DEF = 6;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2,
        PH_ALL_RED = 2'd3
    } phase_e;

endpackage

// File: rtl/traffic_phase_scheduler_arb.sv
// Combinational four-way rotating-priority arbiter: searches last+1 .. last+4
// and returns the first direction with demand.
module rr_arbiter_4 (
    input  logic [3:0] demand,
    input  logic [1:0] last,
    output logic       grant_valid,
    output logic [1:0] grant_dir
);

    always_comb begin
        grant_valid = 1'b0;
        grant_dir   = last;
        // Walk the far end first so the nearest candidate is written last and wins.
        for (int k = 4; k >= 1; k--) begin
            if (demand[2'(last + 2'(k))]) begin
                grant_valid = 1'b1;
                grant_dir   = 2'(last + 2'(k));
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven four-way junction sequencer: GREEN -> YELLOW -> ALL_RED per grant.
// Optional emergency preemption is enabled by defining EMERGENCY_PREEMPT_EN.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 5,
    parameter int ALLRED_T = 2,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [3:0]       req,
    input  logic             emg_req,
    input  logic [1:0]       emg_dir,
    output logic [2:0]       north,
    output logic [2:0]       east,
    output logic [2:0]       south,
    output logic [2:0]       west,
    output logic [1:0]       active_dir,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] countdown,
    output logic [3:0]       pending
);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       active_q, active_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0][2:0]  lamp_q, lamp_d;

    logic [3:0] demand, other;
    logic       arb_valid;
    logic [1:0] arb_dir;
    logic       do_grant;
    logic [1:0] grant_sel;
    logic       emg_on;
    logic [1:0] emg_d;
    logic       emg_preempt, emg_hold;

`ifdef EMERGENCY_PREEMPT_EN
    assign emg_on = emg_req;
    assign emg_d  = emg_dir;
`else
    logic unused_emg;
    assign unused_emg = ^{emg_req, emg_dir};
    assign emg_on = 1'b0;
    assign emg_d  = DIR_N;
`endif

    assign demand      = pending_q | req;
    assign other       = demand & ~(4'b0001 << active_q);
    assign emg_preempt = emg_on && (phase_q == PH_GREEN) && (active_q != emg_d);
    assign emg_hold    = emg_on && (active_q == emg_d);

    rr_arbiter_4 u_arb (
        .demand      (demand),
        .last        (last_q),
        .grant_valid (arb_valid),
        .grant_dir   (arb_dir)
    );

    always_comb begin
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        active_d  = active_q;
        last_d    = last_q;
        do_grant  = 1'b0;
        grant_sel = emg_on ? emg_d : arb_dir;
        // Demand of the direction already in green is being served, so it is not latched.
        pending_d = pending_q | req;
        if (phase_q == PH_GREEN) pending_d[active_q] = pending_q[active_q];

        if (tick) begin
            case (phase_q)
                PH_IDLE: do_grant = emg_on || arb_valid;
                PH_GREEN: begin
                    if (emg_preempt) begin
                        phase_d = PH_YELLOW;
                        cnt_d   = CNT_W'(YELLOW_T);
                    end else if (cnt_q == CNT_W'(1)) begin
                        if ((other != 4'b0) && !emg_hold) begin
                            phase_d = PH_YELLOW;
                            cnt_d   = CNT_W'(YELLOW_T);
                        end else begin
                            cnt_d = CNT_W'(GREEN_T);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                PH_YELLOW: begin
                    if (cnt_q == CNT_W'(1)) begin
                        phase_d = PH_ALL_RED;
                        cnt_d   = CNT_W'(ALLRED_T);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                PH_ALL_RED: begin
                    if (cnt_q == CNT_W'(1)) begin
                        if (emg_on || arb_valid) begin
                            do_grant = 1'b1;
                        end else begin
                            phase_d = PH_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (do_grant) begin
            phase_d              = PH_GREEN;
            cnt_d                = CNT_W'(GREEN_T);
            active_d             = grant_sel;
            last_d               = grant_sel;
            pending_d[grant_sel] = 1'b0;
        end

        for (int i = 0; i < 4; i++) begin
            lamp_d[i] = LAMP_RED;
            if (active_d == 2'(i)) begin
                if (phase_d == PH_GREEN)  lamp_d[i] = LAMP_GREEN;
                if (phase_d == PH_YELLOW) lamp_d[i] = LAMP_YELLOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= PH_IDLE;
            cnt_q     <= '0;
            active_q  <= DIR_W;
            last_q    <= DIR_W;
            pending_q <= 4'b0;
            lamp_q    <= {4{LAMP_RED}};
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            active_q  <= active_d;
            last_q    <= last_d;
            pending_q <= pending_d;
            lamp_q    <= lamp_d;
        end
    end

    assign north      = lamp_q[DIR_N];
    assign east       = lamp_q[DIR_E];
    assign south      = lamp_q[DIR_S];
    assign west       = lamp_q[DIR_W];
    assign active_dir = active_q;
    assign phase      = phase_q;
    assign countdown  = cnt_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with a procedural spec model checked
// every cycle, plus literal expectations from the junction test scenarios.
module tb_traffic_phase_scheduler;

    localparam int GT = 10, YT = 5, AT = 2, CW = 6;

    logic          clk = 1'b0;
    logic          reset, tick, emg_req;
    logic [3:0]    req;
    logic [1:0]    emg_dir;
    logic [2:0]    north, east, south, west;
    logic [1:0]    active_dir, phase;
    logic [CW-1:0] countdown;
    logic [3:0]    pending;

    int checks = 0, errors = 0;

    // model state
    int       m_phase, m_cnt, m_dir, m_last;
    bit [3:0] m_pend;

    // grant-order recording
    bit       rec_en = 0;
    int       gq[$];
    int       prev_phase = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(.GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .tick(tick), .req(req),
        .emg_req(emg_req), .emg_dir(emg_dir),
        .north(north), .east(east), .south(south), .west(west),
        .active_dir(active_dir), .phase(phase), .countdown(countdown), .pending(pending)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input bit [3:0] dem, input int last);
        for (int k = 1; k <= 4; k++)
            if (dem[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic m_grant(input int d, inout bit [3:0] np);
        m_phase = 1; m_cnt = GT; m_dir = d; m_last = d; np[d] = 1'b0;
    endtask

    task automatic model_step();
        bit [3:0] dem, np, oth;
        bit       emg;
        int       w;
        if (reset) begin
            m_phase = 0; m_cnt = 0; m_dir = 3; m_last = 3; m_pend = 0;
            return;
        end
        emg = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
        emg = emg_req;
`endif
        dem = m_pend | req;
        np  = m_pend | req;
        if (m_phase == 1) np[m_dir] = m_pend[m_dir];
        oth = dem;
        oth[m_dir] = 1'b0;
        w = rr_pick(dem, m_last);
        if (tick) begin
            case (m_phase)
                0: if (emg) m_grant(int'(emg_dir), np);
                   else if (w >= 0) m_grant(w, np);
                1: if (emg && m_dir != int'(emg_dir)) begin m_phase = 2; m_cnt = YT; end
                   else if (m_cnt == 1) begin
                       if (oth != 0 && !(emg && m_dir == int'(emg_dir))) begin m_phase = 2; m_cnt = YT; end
                       else m_cnt = GT;
                   end else m_cnt--;
                2: if (m_cnt == 1) begin m_phase = 3; m_cnt = AT; end else m_cnt--;
                default: if (m_cnt == 1) begin
                       if (emg) m_grant(int'(emg_dir), np);
                       else if (w >= 0) m_grant(w, np);
                       else begin m_phase = 0; m_cnt = 0; end
                   end else m_cnt--;
            endcase
        end
        m_pend = np;
    endtask

    function automatic int exp_lamp(input int d);
        if (d == m_dir && m_phase == 1) return 1;
        if (d == m_dir && m_phase == 2) return 2;
        return 4;
    endfunction

    task automatic compare();
        int nonred;
        chk("phase", int'(phase), m_phase);
        chk("countdown", int'(countdown), m_cnt);
        chk("active_dir", int'(active_dir), m_dir);
        chk("pending", int'(pending), int'(m_pend));
        chk("north", int'(north), exp_lamp(0));
        chk("east", int'(east), exp_lamp(1));
        chk("south", int'(south), exp_lamp(2));
        chk("west", int'(west), exp_lamp(3));
        nonred = int'(north != 3'b100) + int'(east != 3'b100) + int'(south != 3'b100) + int'(west != 3'b100);
        chk("one_lamp", int'(nonred <= 1), 1);
    endtask

    task automatic cyc(input logic t);
        tick = t;
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (rec_en && phase == 2'd1 && prev_phase != 1) gq.push_back(int'(active_dir));
        prev_phase = int'(phase);
    endtask

    task automatic do_tick();
        cyc(1'b1);
        cyc(1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b1);
        reset = 1'b0;
    endtask

    initial begin
        int order[5];
        int got, found;
        reset = 1'b1; tick = 1'b0; req = 4'b0; emg_req = 1'b0; emg_dir = 2'd0;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        // 1: idle with no demand
        do_reset();
        chk("rst_phase", int'(phase), 0);
        chk("rst_north", int'(north), 4);
        chk("rst_active", int'(active_dir), 3);
        for (int i = 0; i < 20; i++) do_tick();
        chk("idle_phase", int'(phase), 0);
        chk("idle_cnt", int'(countdown), 0);

        // 2: single N request, then rest in green
        req = 4'b0001; cyc(1'b0); req = 4'b0;
        do_tick();
        chk("n_green", int'(north), 1);
        chk("n_cnt", int'(countdown), 10);
        for (int i = 0; i < 10; i++) do_tick();
        chk("rest_phase", int'(phase), 1);
        chk("rest_cnt", int'(countdown), 10);

        // 3: S request at countdown 4
        for (int i = 0; i < 6; i++) do_tick();
        chk("at4_cnt", int'(countdown), 4);
        req = 4'b0100; cyc(1'b0); req = 4'b0;
        for (int i = 0; i < 4; i++) do_tick();
        chk("y_phase", int'(phase), 2);
        chk("y_cnt", int'(countdown), 5);
        chk("y_north", int'(north), 2);
        for (int i = 0; i < 5; i++) do_tick();
        chk("ar_phase", int'(phase), 3);
        chk("ar_cnt", int'(countdown), 2);
        for (int i = 0; i < 2; i++) do_tick();
        chk("s_phase", int'(phase), 1);
        chk("s_dir", int'(active_dir), 2);
        chk("s_pending", int'(pending), 0);
        chk("s_lamp", int'(south), 1);

        // 4: all requests held, round-robin order
        req = 4'b1111;
        do_reset();
        gq.delete(); rec_en = 1;
        for (int i = 0; i < 70; i++) do_tick();
        rec_en = 0;
        chk("rr_count", gq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            got = (i < gq.size()) ? gq[i] : -1;
            chk($sformatf("rr_order%0d", i), got, order[i]);
        end

        // 5: reset during E yellow at countdown 3
        do_reset();
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            do_tick();
            if (phase == 2'd2 && active_dir == 2'd1 && countdown == 6'd3) found = 1;
        end
        chk("e_yellow3_found", found, 1);
        req = 4'b0; reset = 1'b1; cyc(1'b0); reset = 1'b0;
        chk("mid_rst_phase", int'(phase), 0);
        chk("mid_rst_east", int'(east), 4);
        chk("mid_rst_pending", int'(pending), 0);
        chk("mid_rst_cnt", int'(countdown), 0);
        req = 4'b0011; do_tick(); req = 4'b0;
        chk("after_rst_dir", int'(active_dir), 0);
        chk("after_rst_phase", int'(phase), 1);

        // 6: emergency preemption of N green in favour of S over E
        do_reset();
        req = 4'b0001; cyc(1'b0); req = 4'b0;
        do_tick(); do_tick(); do_tick();
        chk("emg_pre_cnt", int'(countdown), 8);
        emg_req = 1'b1; emg_dir = 2'd2; req = 4'b0010;
        do_tick();
`ifdef EMERGENCY_PREEMPT_EN
        chk("emg_yellow", int'(phase), 2);
        chk("emg_ycnt", int'(countdown), 5);
`else
        chk("noemg_green", int'(phase), 1);
        chk("noemg_cnt", int'(countdown), 7);
`endif
        got = -1;
        for (int i = 0; i < 40 && got < 0; i++) begin
            do_tick();
            if (phase == 2'd1 && active_dir != 2'd0) got = int'(active_dir);
        end
`ifdef EMERGENCY_PREEMPT_EN
        chk("emg_next_dir", got, 2);
`else
        chk("noemg_next_dir", got, 1);
`endif
        emg_req = 1'b0; req = 4'b0;
        for (int i = 0; i < 30; i++) do_tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
